// File: rtl/matmul_tile_scheduler.sv
// -----------------------------------------------------------------------------
// matmul_tile_scheduler
//
// Walks the dot-product PE array across an N x Q output matrix one tile at a
// time. A tile is one mat1 row against a block of NUM_DPS mat2 columns, visited
// row-major. For each tile it requests operand staging, pulses the PE start,
// waits for the array's all-done and issues a masked write-back. A watchdog
// aborts the job if the array never reports done.
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   start           begin a job (only honoured while idle)
//   busy            high from accepted start until done / abort
//   done            one-cycle pulse after the last tile is stored
//   err             sticky watchdog flag, cleared by reset or a new start
//   ld_valid/ready  operand load request handshake, ld_row/ld_col = tile origin
//   ld_done         staging buffers filled
//   dp_start        one-cycle PE array start pulse
//   dp_all_done     all PEs report a valid result
//   st_valid/ready  write-back request handshake, st_row/st_col = tile origin
//   st_mask         per-PE write enable (partial last column block)
//   tile_cnt        tiles stored in the current job
// -----------------------------------------------------------------------------
module matmul_tile_scheduler #(
  parameter int N       = 32,
  parameter int Q       = 32,
  parameter int NUM_DPS = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  ld_valid,
  input  logic                  ld_ready,
  output logic [$clog2(N)-1:0]  ld_row,
  output logic [$clog2(Q)-1:0]  ld_col,
  input  logic                  ld_done,
  output logic                  dp_start,
  input  logic                  dp_all_done,
  output logic                  st_valid,
  input  logic                  st_ready,
  output logic [$clog2(N)-1:0]  st_row,
  output logic [$clog2(Q)-1:0]  st_col,
  output logic [NUM_DPS-1:0]    st_mask,
  output logic [15:0]           tile_cnt
);

  localparam int RW = $clog2(N);
  localparam int CW = $clog2(Q);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_LD,
    S_RUN,
    S_STORE,
    S_DONE
  } state_t;

  state_t          state;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic [TW-1:0]   run_timer;

  // The tile origin registers drive both request interfaces directly, so the
  // address is stable for as long as either valid is held.
  assign ld_row = row;
  assign ld_col = col;
  assign st_row = row;
  assign st_col = col;

  // Only the PEs whose column falls inside the matrix are written back.
  function automatic logic [NUM_DPS-1:0] tile_mask(input logic [CW-1:0] c);
    logic [NUM_DPS-1:0] m;
    m = '0;
    for (int p = 0; p < NUM_DPS; p++) begin
      if (int'(c) + p < Q) m[p] = 1'b1;
    end
    return m;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      run_timer <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      ld_valid  <= 1'b0;
      dp_start  <= 1'b0;
      st_valid  <= 1'b0;
      st_mask   <= '0;
      tile_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            row      <= '0;
            col      <= '0;
            tile_cnt <= '0;
            err      <= 1'b0;
            busy     <= 1'b1;
            ld_valid <= 1'b1;
            state    <= S_REQ;
          end
        end

        S_REQ: begin
          if (ld_ready) begin
            ld_valid <= 1'b0;
            state    <= S_WAIT_LD;
          end
        end

        S_WAIT_LD: begin
          if (ld_done) begin
            dp_start  <= 1'b1;
            run_timer <= '0;
            state     <= S_RUN;
          end
        end

        // The timer counts RUN cycles; all-done on the cycle it reaches
        // TIMEOUT still wins over the watchdog.
        S_RUN: begin
          dp_start  <= 1'b0;
          run_timer <= run_timer + TW'(1);
          if (dp_all_done) begin
            st_valid <= 1'b1;
            st_mask  <= tile_mask(col);
            state    <= S_STORE;
          end else if (int'(run_timer) + 1 >= TIMEOUT) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        S_STORE: begin
          if (st_ready) begin
            st_valid <= 1'b0;
            st_mask  <= '0;
            tile_cnt <= tile_cnt + 16'd1;
            if (int'(col) + NUM_DPS < Q) begin
              col      <= CW'(int'(col) + NUM_DPS);
              ld_valid <= 1'b1;
              state    <= S_REQ;
            end else begin
              col <= '0;
              if (int'(row) == N - 1) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_DONE;
              end else begin
                row      <= row + RW'(1);
                ld_valid <= 1'b1;
                state    <= S_REQ;
              end
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// -----------------------------------------------------------------------------
// tb_matmul_tile_scheduler
//
// Two schedulers: A (N=2, Q=32, one full column block per row) and B (N=2,
// Q=40, a full block plus an 8-column partial block per row). Only one is
// started at a time; a shared responder plays fetcher, PE array and store,
// and checks every handshake against a tile list computed from the matrix
// dimensions.
// -----------------------------------------------------------------------------
module tb_matmul_tile_scheduler;

  localparam int NR = 2;
  localparam int QA = 32;
  localparam int QB = 40;
  localparam int P  = 32;
  localparam int TO = 64;

  typedef struct {
    int          row;
    int          col;
    logic [31:0] mask;
  } tile_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start_a, start_b, ld_ready, ld_done, dp_all_done, st_ready;

  logic        a_busy, a_done, a_err, a_ld_valid, a_dp_start, a_st_valid;
  logic [0:0]  a_ld_row, a_st_row;
  logic [4:0]  a_ld_col, a_st_col;
  logic [31:0] a_st_mask;
  logic [15:0] a_tile_cnt;

  logic        b_busy, b_done, b_err, b_ld_valid, b_dp_start, b_st_valid;
  logic [0:0]  b_ld_row, b_st_row;
  logic [5:0]  b_ld_col, b_st_col;
  logic [31:0] b_st_mask;
  logic [15:0] b_tile_cnt;

  logic        sel;
  logic        o_busy, o_done, o_err, o_ld_valid, o_dp_start, o_st_valid;
  logic [0:0]  o_ld_row, o_st_row;
  logic [5:0]  o_ld_col, o_st_col;
  logic [31:0] o_st_mask;
  logic [15:0] o_tile_cnt;

  int checks = 0;
  int errors = 0;

  matmul_tile_scheduler #(.N(NR), .Q(QA), .NUM_DPS(P), .TIMEOUT(TO)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(a_busy), .done(a_done), .err(a_err),
    .ld_valid(a_ld_valid), .ld_ready(ld_ready), .ld_row(a_ld_row), .ld_col(a_ld_col),
    .ld_done(ld_done), .dp_start(a_dp_start), .dp_all_done(dp_all_done),
    .st_valid(a_st_valid), .st_ready(st_ready), .st_row(a_st_row), .st_col(a_st_col),
    .st_mask(a_st_mask), .tile_cnt(a_tile_cnt));

  matmul_tile_scheduler #(.N(NR), .Q(QB), .NUM_DPS(P), .TIMEOUT(TO)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(b_busy), .done(b_done), .err(b_err),
    .ld_valid(b_ld_valid), .ld_ready(ld_ready), .ld_row(b_ld_row), .ld_col(b_ld_col),
    .ld_done(ld_done), .dp_start(b_dp_start), .dp_all_done(dp_all_done),
    .st_valid(b_st_valid), .st_ready(st_ready), .st_row(b_st_row), .st_col(b_st_col),
    .st_mask(b_st_mask), .tile_cnt(b_tile_cnt));

  always_comb begin
    if (sel) begin
      o_busy = b_busy; o_done = b_done; o_err = b_err;
      o_ld_valid = b_ld_valid; o_dp_start = b_dp_start; o_st_valid = b_st_valid;
      o_ld_row = b_ld_row; o_ld_col = b_ld_col; o_st_row = b_st_row; o_st_col = b_st_col;
      o_st_mask = b_st_mask; o_tile_cnt = b_tile_cnt;
    end else begin
      o_busy = a_busy; o_done = a_done; o_err = a_err;
      o_ld_valid = a_ld_valid; o_dp_start = a_dp_start; o_st_valid = a_st_valid;
      o_ld_row = a_ld_row; o_ld_col = {1'b0, a_ld_col}; o_st_row = a_st_row;
      o_st_col = {1'b0, a_st_col}; o_st_mask = a_st_mask; o_tile_cnt = a_tile_cnt;
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int pick(input int v, input int lo, input int hi);
    if (v >= 0) return v;
    return int'($urandom_range(hi, lo));
  endfunction

  // ld_stall/st_stall: not-ready cycles per request, ld_del: cycles from load
  // handshake to ld_done, lat: cycles from dp_start to dp_all_done (-1 random,
  // -2 never), noise: spurious start/ld_done/dp_all_done, rst_tile: pulse reset
  // during RUN of that tile index (-1 none).
  task automatic run_job(input bit use_b, input int ld_stall, input int st_stall,
                         input int ld_del, input int lat, input bit noise,
                         input int rst_tile);
    tile_t       tiles[$];
    tile_t       t;
    int          qn, ld_i, st_i, ld_wait, st_wait, ld_done_cnt, ad_cnt, run_cnt, dps;
    bit          in_run, ld_done_given, prev_ld_wait, prev_st_wait, finished, timed_out, was_reset;
    logic [0:0]  h_ld_row, h_st_row;
    logic [5:0]  h_ld_col, h_st_col;
    logic [31:0] h_mask;

    qn = use_b ? QB : QA;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < qn; c += P) begin
        t.row  = r;
        t.col  = c;
        t.mask = (qn - c >= P) ? 32'hFFFF_FFFF : 32'((64'd1 << (qn - c)) - 64'd1);
        tiles.push_back(t);
      end
    end

    sel = use_b;
    ld_i = 0; st_i = 0; ld_done_cnt = 0; ad_cnt = 0; run_cnt = 0; dps = 0;
    in_run = 0; ld_done_given = 0; prev_ld_wait = 0; prev_st_wait = 0;
    finished = 0; timed_out = 0; was_reset = 0;
    h_ld_row = '0; h_st_row = '0; h_ld_col = '0; h_st_col = '0; h_mask = '0;
    ld_wait = pick(ld_stall, 0, 3);
    st_wait = pick(st_stall, 0, 4);
    ld_ready = 1'b0; st_ready = 1'b0; ld_done = 1'b0; dp_all_done = 1'b0;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    chk("start_busy", o_busy, 1);
    chk("start_err_clear", o_err, 0);
    chk("start_tile_cnt", o_tile_cnt, 0);

    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      ld_done = 1'b0;
      dp_all_done = 1'b0;
      if (noise) begin
        if (use_b) start_b = 1'($urandom); else start_a = 1'($urandom);
        if (o_ld_valid || o_st_valid) dp_all_done = 1'($urandom);
        if (o_ld_valid) ld_done = 1'($urandom);
      end
      chk("one_hot", ($countones({o_ld_valid, o_dp_start, o_st_valid}) <= 1), 1);

      if (ld_done_cnt > 0) begin
        ld_done_cnt--;
        if (ld_done_cnt == 0) begin ld_done = 1'b1; ld_done_given = 1'b1; end
      end
      if (ad_cnt > 0) begin
        ad_cnt--;
        if (ad_cnt == 0) dp_all_done = 1'b1;
      end

      if (o_dp_start) begin
        dps++;
        chk("dp_start_once", dps, 1);
        chk("dp_start_after_ld_done", ld_done_given, 1);
        ld_done_given = 1'b0;
        in_run = 1'b1;
        run_cnt = 1;
        ad_cnt = (lat == -2) ? 0 : pick(lat, 1, 10);
        if (rst_tile >= 0 && ld_i - 1 == rst_tile) begin
          #1 reset = 1'b0;
          #1;
          chk("rst_flags", {o_busy, o_done, o_err, o_ld_valid, o_dp_start, o_st_valid}, 0);
          chk("rst_rowcol", {o_ld_row, o_ld_col, o_st_row, o_st_col}, 0);
          chk("rst_mask", o_st_mask, 0);
          chk("rst_tile_cnt", o_tile_cnt, 0);
          ld_done = 1'b0; dp_all_done = 1'b0;
          @(negedge clk);
          reset = 1'b1;
          finished = 1'b1;
          was_reset = 1'b1;
        end
      end else if (in_run) begin
        run_cnt++;
        if (lat == -2 && run_cnt == TO) begin
          chk("to_err_early", o_err, 0);
          chk("to_busy_early", o_busy, 1);
        end
        if (lat == -2 && run_cnt == TO + 1) begin
          chk("to_err", o_err, 1);
          chk("to_busy", o_busy, 0);
          chk("to_no_done", o_done, 0);
          timed_out = 1'b1;
          finished = 1'b1;
        end
      end

      if (!finished) begin
        if (!o_done) chk("busy_held", o_busy, 1);

        if (prev_ld_wait) begin
          chk("ld_valid_hold", o_ld_valid, 1);
          chk("ld_row_hold", o_ld_row, h_ld_row);
          chk("ld_col_hold", o_ld_col, h_ld_col);
        end
        prev_ld_wait = 1'b0;
        if (o_ld_valid) begin
          if (ld_wait > 0) begin
            ld_ready = 1'b0;
            ld_wait--;
            prev_ld_wait = 1'b1;
            h_ld_row = o_ld_row;
            h_ld_col = o_ld_col;
          end else begin
            ld_ready = 1'b1;
            chk("ld_in_range", ld_i < tiles.size(), 1);
            if (ld_i < tiles.size()) begin
              chk("ld_row", o_ld_row, tiles[ld_i].row);
              chk("ld_col", o_ld_col, tiles[ld_i].col);
            end
            ld_i++;
            dps = 0;
            ld_done_cnt = pick(ld_del, 1, 3);
            ld_wait = pick(ld_stall, 0, 3);
          end
        end else begin
          ld_ready = 1'($urandom);
        end

        if (prev_st_wait) begin
          chk("st_valid_hold", o_st_valid, 1);
          chk("st_row_hold", o_st_row, h_st_row);
          chk("st_col_hold", o_st_col, h_st_col);
          chk("st_mask_hold", o_st_mask, h_mask);
        end
        prev_st_wait = 1'b0;
        if (o_st_valid) begin
          if (in_run) chk("store_err_low", o_err, 0);
          in_run = 1'b0;
          if (st_wait > 0) begin
            st_ready = 1'b0;
            st_wait--;
            prev_st_wait = 1'b1;
            h_st_row = o_st_row;
            h_st_col = o_st_col;
            h_mask = o_st_mask;
          end else begin
            st_ready = 1'b1;
            chk("st_in_range", st_i < tiles.size(), 1);
            if (st_i < tiles.size()) begin
              chk("st_row", o_st_row, tiles[st_i].row);
              chk("st_col", o_st_col, tiles[st_i].col);
              chk("st_mask", o_st_mask, tiles[st_i].mask);
            end
            chk("tile_cnt_pre", o_tile_cnt, st_i);
            st_i++;
            st_wait = pick(st_stall, 0, 4);
          end
        end else begin
          st_ready = 1'($urandom);
        end

        if (o_done) begin
          chk("done_busy_low", o_busy, 0);
          chk("done_loads", ld_i, tiles.size());
          chk("done_stores", st_i, tiles.size());
          chk("done_tile_cnt", o_tile_cnt, tiles.size());
          start_a = 1'b0; start_b = 1'b0;
          finished = 1'b1;
        end
      end

      if (!finished) @(negedge clk);
    end

    chk("job_finished", finished, 1);
    start_a = 1'b0; start_b = 1'b0; ld_done = 1'b0; dp_all_done = 1'b0;

    if (timed_out) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("to_err_sticky", o_err, 1);
        chk("to_done_never", o_done, 0);
        chk("to_idle_busy", o_busy, 0);
      end
    end else if (!was_reset && finished) begin
      @(negedge clk);
      chk("done_one_pulse", o_done, 0);
      chk("idle_busy", o_busy, 0);
      chk("tile_cnt_hold", o_tile_cnt, tiles.size());
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
    ld_ready = 1'b0; ld_done = 1'b0; dp_all_done = 1'b0; st_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_a_flags", {a_busy, a_done, a_err, a_ld_valid, a_dp_start, a_st_valid}, 0);
    chk("reset_a_addr", {a_ld_row, a_ld_col, a_st_row, a_st_col}, 0);
    chk("reset_a_mask_cnt", {a_st_mask, a_tile_cnt}, 0);
    chk("reset_b_flags", {b_busy, b_done, b_err, b_ld_valid, b_dp_start, b_st_valid}, 0);
    chk("reset_b_addr", {b_ld_row, b_ld_col, b_st_row, b_st_col}, 0);
    chk("reset_b_mask_cnt", {b_st_mask, b_tile_cnt}, 0);
    reset = 1'b1;
    @(negedge clk);

    run_job(1'b0, 0, 0, 1, 5, 1'b0, -1);    // full blocks, zero-wait
    run_job(1'b1, 0, 0, 1, 5, 1'b0, -1);    // partial last block
    run_job(1'b0, 3, 4, 1, 5, 1'b0, -1);    // stalled fetch and store
    run_job(1'b1, 3, 4, 2, 5, 1'b0, -1);
    run_job(1'b1, 0, 0, 1, 63, 1'b0, -1);   // all-done on the watchdog cycle
    run_job(1'b0, 0, 0, 1, -2, 1'b0, -1);   // watchdog abort
    run_job(1'b0, 0, 0, 1, 5, 1'b0, -1);    // restart clears err
    run_job(1'b1, 0, 0, 1, 5, 1'b0, 1);     // reset during RUN of tile 1
    run_job(1'b1, 0, 0, 1, 5, 1'b0, -1);    // restart from tile (0,0)
    run_job(1'b0, 0, 0, 1, 5, 1'b1, -1);    // spurious start / done inputs
    for (int j = 0; j < 6; j++) begin
      run_job(1'(j), -1, -1, -1, -1, 1'($urandom), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
